muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 169 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: single-cycle multiply, 32-step restoring divide,
// with pipeline stall/done handshake toward the EX stage.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            is_rem_q, is_rem_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;

  logic            accept;
  logic            a_sgn_mul, b_sgn_mul;
  logic [63:0]     mul_a, mul_b, prod;
  logic [XLEN-1:0] mul_res;
  logic            div_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   trial, diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_step, quo_step, q_fix, r_fix, div_res;
  logic            unused_bits;

  assign unused_bits = alu_control[3];

  // Handshake: accept when IDLE & start & M-op & !flush; stall holds the
  // pipeline from the accept cycle until the cycle in which done is high.
  assign accept    = (state_q == S_IDLE) && start && alu_control[4] && !flush;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign stall     = !rst && (accept || (busy && !done_q));
  assign dbg_state = state_q;

  always_comb begin
    a_sgn_mul = (alu_control[1:0] == 2'b01) || (alu_control[1:0] == 2'b10);
    b_sgn_mul = (alu_control[1:0] == 2'b01);
    mul_a     = {{32{a_sgn_mul & op_a[31]}}, op_a};
    mul_b     = {{32{b_sgn_mul & op_b[31]}}, op_b};
    prod      = mul_a * mul_b;
    mul_res   = (alu_control[1:0] == 2'b00) ? prod[31:0] : prod[63:32];

    div_sgn   = !alu_control[0];
    a_neg     = div_sgn & op_a[31];
    b_neg     = div_sgn & op_b[31];
    mag_a     = a_neg ? (32'd0 - op_a) : op_a;
    mag_b     = b_neg ? (32'd0 - op_b) : op_b;
    div_zero  = (op_b == 32'd0);
    div_ovf   = div_sgn && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    trial     = {rem_q, quo_q[31]};
    diff      = trial - {1'b0, dvs_q};
    q_bit     = !diff[XLEN];
    rem_step  = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
    quo_step  = {quo_q[30:0], q_bit};
    q_fix     = q_neg_q ? (32'd0 - quo_step) : quo_step;
    r_fix     = r_neg_q ? (32'd0 - rem_step) : rem_step;
    div_res   = is_rem_q ? r_fix : q_fix;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!alu_control[2]) begin
            result_d = mul_res;
            done_d   = 1'b1;
            state_d  = S_MUL;
          end else if (div_zero) begin
            result_d = alu_control[1] ? op_a : 32'hFFFF_FFFF;
            done_d   = 1'b1;
            state_d  = S_FIN;
          end else if (div_ovf) begin
            result_d = alu_control[1] ? 32'd0 : 32'h8000_0000;
            done_d   = 1'b1;
            state_d  = S_FIN;
          end else begin
            rem_d    = 32'd0;
            quo_d    = mag_a;
            dvs_d    = mag_b;
            is_rem_d = alu_control[1];
            q_neg_d  = a_neg ^ b_neg;
            r_neg_d  = a_neg;
            cnt_d    = 5'd0;
            state_d  = S_DIV;
          end
        end
      end
      S_DIV: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 5'd1;
        // Sign correction is folded into the last step so done shows in FIN.
        if (cnt_q == 5'd31) begin
          result_d = div_res;
          done_d   = 1'b1;
          cnt_d    = 5'd0;
          state_d  = S_FIN;
        end
      end
      S_MUL, S_FIN: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = 5'd0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      is_rem_q <= is_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed results, latency,
// stall length, flush and reset aborts, and no re-latch while busy.
module tb_muldiv_sequencer;

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [4:0]  alu_control;
  logic [31:0] op_a, op_b;
  logic        stall, busy, done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
    .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall), .busy(busy),
    .done(done), .result(result), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one op and follows it to done; with hold set, start stays high
  // and the operands are scrambled while busy, so only the latched values count.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input bit hold);
    int lat;
    int stalls;
    @(negedge clk);
    start = 1'b1; alu_control = op; op_a = a; op_b = b;
    #1;
    stalls = stall ? 1 : 0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (hold) begin
        op_a = $urandom; op_b = $urandom;
        alu_control = OP_MUL | 5'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
      #1;
      if (done) break;
      if (stall) stalls++;
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
    check({tag, "_stall_in_done"}, 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_done_single"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int dcount;
    rst = 1'b1; flush = 1'b0;
    start = 1'b1; alu_control = OP_DIV; op_a = 32'd100; op_b = 32'd7;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    // Non-M op must be ignored.
    @(negedge clk);
    start = 1'b1; alu_control = 5'b00010;
    #1;
    check("nonm_stall", 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    check("nonm_busy", 32'(busy), 32'd0);
    start = 1'b0;

    run_op("mulh_neg",  OP_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("mul_6x7",   OP_MUL,    32'd6,         32'd7,         32'h0000_002A, 1, 1'b0);
    run_op("mulhu_max", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 1'b0);
    run_op("mulhsu",    OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("mulh_m1",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0);
    run_op("div_m7_2",  OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_m7_2",  OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
    run_op("div_7_m2",  OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_7_m2",  OP_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
    run_op("divu_max1", OP_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu_z",    OP_DIVU,   32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1, 1'b0);
    run_op("remu_z",    OP_REMU,   32'h0000_1234, 32'd0,         32'h0000_1234, 1, 1'b0);
    run_op("rem_z_neg", OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1, 1'b0);
    run_op("div_ovf",   OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op("rem_ovf",   OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0);
    run_op("divu_hold", OP_DIVU,   32'd100,       32'd7,         32'h0000_000E, 33, 1'b1);
    run_op("remu_hold", OP_REMU,   32'd100,       32'd7,         32'h0000_0002, 33, 1'b1);

    // Flush at DIV cycle 10: previous result (2) must hold, no done.
    @(negedge clk);
    start = 1'b1; alu_control = OP_DIVU; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_result", result, 32'h0000_0002);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("flush_no_done", 32'(dcount), 32'd0);
    run_op("mul_after_flush", OP_MUL, 32'd6, 32'd7, 32'h0000_002A, 1, 1'b0);

    // Reset at DIV cycle 20 with start held high.
    @(negedge clk);
    start = 1'b1; alu_control = OP_DIV; op_a = 32'd500; op_b = 32'd9;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midrst_no_done", 32'(dcount), 32'd0);
    run_op("div_after_rst", OP_DIV, 32'd500, 32'd9, 32'h0000_0037, 33, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
